// File: rtl/simd_pkg.sv
// ---------------------------------------------------------------------------
// simd_pkg
//   Shared definitions for the SIMD lane array: opcode encoding and the
//   default geometry used by simd_lane_array and simd_lane.
// ---------------------------------------------------------------------------
package simd_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 2'b00,
    OP_SUB    = 2'b01,
    OP_MUL    = 2'b10,
    OP_BITREV = 2'b11
  } op_e;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_NUM_LANES = 4;
  localparam int DEF_REG_COUNT = 32;

endpackage

// File: rtl/simd_lane.sv
// ---------------------------------------------------------------------------
// simd_lane
//   One SIMD lane: private register file (two read ports, one writeback port
//   plus a host load port), an unsigned ALU and the S2 result register.
// Ports
//   clk, rst              clock, synchronous active-high reset
//   i_rd_en               instruction accepted: capture operands into S1
//   i_rs1, i_rs2          source register addresses
//   i_vld_p1, i_op_p1     S1 valid and opcode (from the shared control pipe)
//   i_en_p1               this lane's mask bit for the S1 instruction
//   i_wb_en, i_wb_addr    writeback of the S2 result into the register file
//   i_ld_en/addr/data     host register load (dropped if writeback hits it)
//   o_res_p2              S2 result, zero when the lane was masked off
// ---------------------------------------------------------------------------
module simd_lane
  import simd_pkg::*;
#(
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int REG_COUNT = DEF_REG_COUNT,
  localparam int ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rs1,
  input  logic [ADDR_W-1:0] i_rs2,
  input  logic              i_vld_p1,
  input  op_e               i_op_p1,
  input  logic              i_en_p1,
  input  logic              i_wb_en,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic              i_ld_en,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_data,
  output logic [DATA_W-1:0] o_res_p2
);

  function automatic logic [DATA_W-1:0] bitrev(input logic [DATA_W-1:0] a);
    logic [DATA_W-1:0] r;
    for (int k = 0; k < DATA_W; k++) r[k] = a[DATA_W-1-k];
    return r;
  endfunction

  logic [DATA_W-1:0] r_rf [REG_COUNT];
  logic [DATA_W-1:0] r_a_p1;
  logic [DATA_W-1:0] r_b_p1;
  logic [DATA_W-1:0] r_res_p2;
  logic [DATA_W-1:0] w_alu;
  logic              w_ld_we;

  // A load colliding with writeback on the same register loses.
  assign w_ld_we = i_ld_en && !(i_wb_en && (i_wb_addr == i_ld_addr));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) r_rf[i] <= '0;
    end else begin
      if (w_ld_we) r_rf[i_ld_addr] <= i_ld_data;
      if (i_wb_en) r_rf[i_wb_addr] <= r_res_p2;
    end
  end

  // ---- S1: operands captured at the accept edge ----
  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_a_p1 <= r_rf[i_rs1];
      r_b_p1 <= r_rf[i_rs2];
    end
  end

  always_comb begin
    w_alu = '0;
    case (i_op_p1)
      OP_ADD:    w_alu = r_a_p1 + r_b_p1;
      OP_SUB:    w_alu = r_a_p1 - r_b_p1;
      OP_MUL:    w_alu = r_a_p1 * r_b_p1;
      OP_BITREV: w_alu = bitrev(r_a_p1);
      default:   w_alu = '0;
    endcase
  end

  // ---- S2: result register, also the writeback source ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_p2 <= '0;
    end else if (i_vld_p1) begin
      r_res_p2 <= i_en_p1 ? w_alu : '0;
    end
  end

  assign o_res_p2 = r_res_p2;

endmodule

// File: rtl/simd_lane_array.sv
// ---------------------------------------------------------------------------
// simd_lane_array
//   NUM_LANES-wide SIMD execute core. One instruction stream is issued over a
//   valid/ready handshake and executed in every enabled lane. The top owns
//   the handshake, the RAW hazard check and the S1/S2 control pipeline; the
//   lanes own register files, ALUs and result registers.
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           issue handshake (in_ready combinational)
//   in_op, in_rs1, in_rs2, in_rd  instruction fields
//   in_mask                       per-lane enable
//   ld_en, ld_lane, ld_addr, ld_data  host register load
//   res_valid, res_rd, res_mask, res_data  registered result beat
// ---------------------------------------------------------------------------
module simd_lane_array
  import simd_pkg::*;
#(
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int NUM_LANES = DEF_NUM_LANES,
  parameter  int REG_COUNT = DEF_REG_COUNT,
  localparam int ADDR_W    = $clog2(REG_COUNT),
  localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [OP_W-1:0]               in_op,
  input  logic [ADDR_W-1:0]             in_rs1,
  input  logic [ADDR_W-1:0]             in_rs2,
  input  logic [ADDR_W-1:0]             in_rd,
  input  logic [NUM_LANES-1:0]          in_mask,
  input  logic                          ld_en,
  input  logic [LANE_W-1:0]             ld_lane,
  input  logic [ADDR_W-1:0]             ld_addr,
  input  logic [DATA_W-1:0]             ld_data,
  output logic                          res_valid,
  output logic [ADDR_W-1:0]             res_rd,
  output logic [NUM_LANES-1:0]          res_mask,
  output logic [NUM_LANES*DATA_W-1:0]   res_data
);

  logic                 r_vld_p1;
  op_e                  r_op_p1;
  logic [ADDR_W-1:0]    r_rd_p1;
  logic [NUM_LANES-1:0] r_mask_p1;
  logic                 r_vld_p2;
  logic [ADDR_W-1:0]    r_rd_p2;
  logic [NUM_LANES-1:0] r_mask_p2;

  logic w_rs2_used;
  logic w_haz_p1;
  logic w_haz_p2;
  logic w_accept;

  // An in-flight instruction with an all-zero mask writes nothing, so it
  // cannot create a hazard. BITREV does not read rs2.
  assign w_rs2_used = (op_e'(in_op) != OP_BITREV);
  assign w_haz_p1   = r_vld_p1 && (|r_mask_p1) &&
                      ((in_rs1 == r_rd_p1) || (w_rs2_used && (in_rs2 == r_rd_p1)));
  assign w_haz_p2   = r_vld_p2 && (|r_mask_p2) &&
                      ((in_rs1 == r_rd_p2) || (w_rs2_used && (in_rs2 == r_rd_p2)));

  // A host load owns the register file for the cycle, so issue waits.
  assign in_ready = !rst && !ld_en && !w_haz_p1 && !w_haz_p2;
  assign w_accept = in_valid && in_ready;

  // ---- S1: instruction control captured at accept ----
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op_p1   <= op_e'(in_op);
      r_rd_p1   <= in_rd;
      r_mask_p1 <= in_mask;
    end
  end

  // ---- S2: result beat control, writeback at the following edge ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_rd_p2   <= '0;
      r_mask_p2 <= '0;
    end else begin
      r_vld_p1 <= w_accept;
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_rd_p2   <= r_rd_p1;
        r_mask_p2 <= r_mask_p1;
      end
    end
  end

  assign res_valid = r_vld_p2;
  assign res_rd    = r_rd_p2;
  assign res_mask  = r_mask_p2;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    simd_lane #(
      .DATA_W    (DATA_W),
      .REG_COUNT (REG_COUNT)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_rd_en   (w_accept),
      .i_rs1     (in_rs1),
      .i_rs2     (in_rs2),
      .i_vld_p1  (r_vld_p1),
      .i_op_p1   (r_op_p1),
      .i_en_p1   (r_mask_p1[gi]),
      .i_wb_en   (r_vld_p2 && r_mask_p2[gi]),
      .i_wb_addr (r_rd_p2),
      .i_ld_en   (ld_en && (int'(ld_lane) == gi)),
      .i_ld_addr (ld_addr),
      .i_ld_data (ld_data),
      .o_res_p2  (res_data[gi*DATA_W +: DATA_W])
    );
  end

endmodule
